// File: rtl/cache_read_data_unit.sv
// Cache read-data unit: extracts, right-aligns and extends a sub-word from a cache line,
// then returns it through a small val/rdy response queue. Optional sign extension: CACHE_RDU_SIGN_EXT_EN.
module cache_read_data_unit #(
    parameter int p_line_nbytes = 16,
    parameter int p_num_entries = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_val,
    output logic                           in_rdy,
    input  logic [8*p_line_nbytes-1:0]     in_line,
    input  logic [$clog2(p_line_nbytes)-1:0] in_offset,
    input  logic [$clog2(p_line_nbytes)-1:0] in_len,
    input  logic                           in_signed,
    output logic                           out_val,
    input  logic                           out_rdy,
    output logic [8*p_line_nbytes-1:0]     out_data,
    output logic                           out_err
);

    localparam int LW  = 8 * p_line_nbytes;
    localparam int OW  = $clog2(p_line_nbytes);
    localparam int FD  = p_num_entries - 1;
    localparam int PW  = (FD > 1) ? $clog2(FD) : 1;
    localparam int FCW = $clog2(FD + 1);
    localparam int CW  = $clog2(p_num_entries + 1);

    // ------------------------------------------------------------------
    // Extraction (combinational, request side)
    // ------------------------------------------------------------------
    logic [OW:0]   off_ext;
    logic [OW:0]   nbytes;
    logic [OW:0]   end_pos;
    logic          len_bad;
    logic          range_bad;
    logic          full_bad;
    logic          res_err;
    logic [LW-1:0] shifted;
    logic [LW-1:0] ext_data;
    logic [LW-1:0] res_data;
    logic [7:0]    shifted_bytes [p_line_nbytes];
    logic          fill_bit;

    assign off_ext   = {1'b0, in_offset};
    assign nbytes    = (in_len == '0) ? (OW+1)'(p_line_nbytes) : {1'b0, in_len};
    assign end_pos   = off_ext + nbytes;
    assign len_bad   = (in_len & (in_len - OW'(1))) != '0;
    assign range_bad = end_pos > (OW+1)'(p_line_nbytes);
    assign full_bad  = (in_len == '0) && (in_offset != '0);
    assign res_err   = len_bad | range_bad | full_bad;
    assign shifted   = in_line >> {in_offset, 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < p_line_nbytes; gi++) begin : g_byte
            localparam logic [OW:0] BYTE_IDX = (OW+1)'(gi);
            assign shifted_bytes[gi]  = shifted[gi*8 +: 8];
            assign ext_data[gi*8 +: 8] = (BYTE_IDX < nbytes) ? shifted_bytes[gi] : {8{fill_bit}};
        end
    endgenerate

`ifdef CACHE_RDU_SIGN_EXT_EN
    logic [OW-1:0] last_byte;
    assign last_byte = OW'(nbytes - (OW+1)'(1));
    // Full-line reads have nothing above the MSB to fill.
    assign fill_bit  = in_signed & (in_len != '0) & shifted_bytes[last_byte][7];
`else
    logic unused_signed;
    assign unused_signed = in_signed;
    assign fill_bit      = 1'b0;
`endif

    assign res_data = res_err ? '0 : ext_data;

    // ------------------------------------------------------------------
    // Response queue: one output register plus (p_num_entries-1) backing slots
    // ------------------------------------------------------------------
    logic [LW:0]    mem [FD];
    logic [PW-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [FCW-1:0] fifo_cnt_reg, fifo_cnt_next;
    logic [CW-1:0]  count_reg, count_next;
    logic           in_rdy_reg, in_rdy_next;
    logic           out_val_reg, out_val_next;
    logic [LW-1:0]  out_data_reg, out_data_next;
    logic           out_err_reg, out_err_next;

    logic enq, deq, fifo_empty, load_from_fifo, load_from_in, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    assign enq            = in_val & in_rdy_reg;
    assign deq            = out_val_reg & out_rdy;
    assign fifo_empty     = (fifo_cnt_reg == '0);
    assign load_from_fifo = deq & ~fifo_empty;
    // The output register takes the request directly when nothing older is waiting.
    assign load_from_in   = enq & (~out_val_reg | (deq & fifo_empty));
    assign push           = enq & ~load_from_in;
    assign pop            = load_from_fifo;

    always_comb begin
        count_next    = count_reg;
        fifo_cnt_next = fifo_cnt_reg;
        rd_ptr_next   = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        wr_ptr_next   = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        out_val_next  = out_val_reg;
        out_data_next = out_data_reg;
        out_err_next  = out_err_reg;

        case ({enq, deq})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase

        case ({push, pop})
            2'b10:   fifo_cnt_next = fifo_cnt_reg + FCW'(1);
            2'b01:   fifo_cnt_next = fifo_cnt_reg - FCW'(1);
            default: fifo_cnt_next = fifo_cnt_reg;
        endcase

        if (load_from_fifo) begin
            {out_err_next, out_data_next} = mem[rd_ptr_reg];
            out_val_next = 1'b1;
        end else if (load_from_in) begin
            out_err_next  = res_err;
            out_data_next = res_data;
            out_val_next  = 1'b1;
        end else if (deq) begin
            out_val_next = 1'b0;
        end

        in_rdy_next = count_next < CW'(p_num_entries);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg    <= '0;
            fifo_cnt_reg <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            in_rdy_reg   <= 1'b0;
            out_val_reg  <= 1'b0;
            out_data_reg <= '0;
            out_err_reg  <= 1'b0;
        end else begin
            count_reg    <= count_next;
            fifo_cnt_reg <= fifo_cnt_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            in_rdy_reg   <= in_rdy_next;
            out_val_reg  <= out_val_next;
            out_data_reg <= out_data_next;
            out_err_reg  <= out_err_next;
        end
    end

    // Storage needs no reset: occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {res_err, res_data};
        end
    end

    assign in_rdy   = in_rdy_reg;
    assign out_val  = out_val_reg;
    assign out_data = out_data_reg;
    assign out_err  = out_err_reg;

endmodule

// File: tb/tb_cache_read_data_unit.sv
// Scoreboard bench for cache_read_data_unit: driver pushes expected responses, monitor pops and compares.
module tb_cache_read_data_unit;

    localparam int NB = 16;
    localparam int LW = 8 * NB;
    localparam int OW = 4;

    localparam logic [LW-1:0] LINE  = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [LW-1:0] LINE2 = 128'h0F0E0D0C0B0A09080706800403020100;

`ifdef CACHE_RDU_SIGN_EXT_EN
    localparam logic [LW-1:0] EXP_S80   = {{120{1'b1}}, 8'h80};
    localparam logic [LW-1:0] EXP_S8004 = {{112{1'b1}}, 16'h8004};
`else
    localparam logic [LW-1:0] EXP_S80   = 128'h80;
    localparam logic [LW-1:0] EXP_S8004 = 128'h8004;
`endif

    logic          clk, reset;
    logic          in_val, in_rdy, in_signed;
    logic [LW-1:0] in_line;
    logic [OW-1:0] in_offset, in_len;
    logic          out_val, out_rdy, out_err;
    logic [LW-1:0] out_data;

    typedef struct packed {
        logic          err;
        logic [LW-1:0] data;
    } resp_t;

    resp_t exp_q [$];
    int    pop_cyc [$];
    int    acc_cyc [$];
    int    checks = 0;
    int    passed = 0;
    int    cyc = 0;

    cache_read_data_unit #(.p_line_nbytes(NB), .p_num_entries(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_val    (in_val),
        .in_rdy    (in_rdy),
        .in_line   (in_line),
        .in_offset (in_offset),
        .in_len    (in_len),
        .in_signed (in_signed),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: a response transfers on the next rising edge when out_val & out_rdy here.
    always @(negedge clk) begin
        if (!reset && out_val && out_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp: got data %0h err %0b expected no response", out_data, out_err);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                pop_cyc.push_back(cyc);
                checks++;
                if (out_data === e.data && out_err === e.err) passed++;
                else $display("FAIL resp: got data %0h err %0b expected data %0h err %0b",
                              out_data, out_err, e.data, e.err);
                $display("resp cyc=%0d data=%0h err=%0b", cyc, out_data, out_err);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [LW-1:0] line, input int off, input int len, input logic sgn,
                        input logic [LW-1:0] ed, input logic ee);
        int n;
        n = 0;
        in_val = 1'b1; in_line = line; in_offset = OW'(off); in_len = OW'(len); in_signed = sgn;
        forever begin
            @(negedge clk);
            if (in_rdy) break;
            n++;
            if (n > 50) begin
                checks++;
                $display("FAIL accept_timeout: got in_rdy 0 for %0d cycles expected acceptance", n);
                in_val = 1'b0;
                return;
            end
        end
        exp_q.push_back({ee, ed});
        acc_cyc.push_back(cyc);
        $display("req cyc=%0d off=%0d len=%0d sgn=%0b", cyc, off, len, sgn);
        @(posedge clk); #1;
        in_val = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; in_val = 1'b0; in_line = '0; in_offset = '0; in_len = '0;
        in_signed = 1'b0; out_rdy = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_rdy", LW'(in_rdy), '0);
        check("rst_out_val", LW'(out_val), '0);
        check("rst_out_data", out_data, '0);
        check("rst_out_err", LW'(out_err), '0);
        reset = 1'b0;
        @(negedge clk);
        check("rel_in_rdy", LW'(in_rdy), LW'(1));
        @(posedge clk); #1;

        // 1: basic extraction and latency
        send(LINE, 4, 4, 1'b0, 128'h07060504, 1'b0);
        check("lat_out_val", LW'(out_val), LW'(1));
        drain();

        // 2: full line, boundaries and errors
        send(LINE, 0, 0, 1'b0, LINE, 1'b0);
        send(LINE, 14, 4, 1'b0, '0, 1'b1);
        send(LINE, 0, 3, 1'b0, '0, 1'b1);
        send(LINE, 1, 0, 1'b0, '0, 1'b1);
        send(LINE, 0, 5, 1'b0, '0, 1'b1);
        send(LINE, 15, 2, 1'b0, '0, 1'b1);
        send(LINE, 15, 1, 1'b0, 128'h0F, 1'b0);
        send(LINE, 12, 4, 1'b0, 128'h0F0E0D0C, 1'b0);
        send(LINE, 8, 8, 1'b0, 128'h0F0E0D0C0B0A0908, 1'b0);
        drain();

        // 3: sign extension
        send(LINE2, 5, 1, 1'b1, EXP_S80, 1'b0);
        send(LINE2, 5, 1, 1'b0, 128'h80, 1'b0);
        send(LINE2, 4, 2, 1'b1, EXP_S8004, 1'b0);
        send(LINE2, 4, 1, 1'b1, 128'h04, 1'b0);
        send(LINE2, 0, 0, 1'b1, LINE2, 1'b0);
        send(LINE2, 14, 4, 1'b1, '0, 1'b1);
        drain();

        // 4: full queue backpressure, no bypass
        out_rdy = 1'b0;
        send(LINE, 0, 2, 1'b0, 128'h0100, 1'b0);
        send(LINE, 2, 2, 1'b0, 128'h0302, 1'b0);
        in_val = 1'b1; in_line = LINE; in_offset = OW'(4); in_len = OW'(2); in_signed = 1'b0;
        @(negedge clk);
        check("full_in_rdy", LW'(in_rdy), '0);
        check("full_out_val", LW'(out_val), LW'(1));
        @(posedge clk); #1;
        out_rdy = 1'b1;
        @(negedge clk);
        check("full_no_bypass", LW'(in_rdy), '0);
        @(posedge clk); #1;
        send(LINE, 4, 2, 1'b0, 128'h0504, 1'b0);
        drain();
        check("order_consecutive", LW'(pop_cyc[$] - pop_cyc[$-2]), LW'(2));

        // 5: back-to-back throughput
        for (int i = 0; i < 8; i++) begin
            send(LINE, i, 1, 1'b0, LW'(i), 1'b0);
        end
        drain();
        check("b2b_accepts", LW'(acc_cyc[$] - acc_cyc[$-7]), LW'(7));
        check("b2b_responses", LW'(pop_cyc[$] - pop_cyc[$-7]), LW'(7));

        // 6: asynchronous reset with two entries queued
        out_rdy = 1'b0;
        send(LINE, 9, 1, 1'b0, 128'h09, 1'b0);
        send(LINE, 10, 1, 1'b0, 128'h0A, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("arst_out_val", LW'(out_val), '0);
        check("arst_in_rdy", LW'(in_rdy), '0);
        check("arst_out_data", out_data, '0);
        in_val = 1'b1; in_line = LINE; in_offset = OW'(3); in_len = OW'(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        in_val = 1'b0;
        out_rdy = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_rdy", LW'(in_rdy), LW'(1));
        check("post_rst_out_val", LW'(out_val), '0);
        repeat (3) @(negedge clk);
        check("no_stale_out_val", LW'(out_val), '0);
        @(posedge clk); #1;
        send(LINE, 6, 2, 1'b0, 128'h0706, 1'b0);
        drain();

        check("scoreboard_empty", LW'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
